// File: rtl/gf_inv_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : gf_inv_div_seq
//  Purpose  : Sequential GF(2^M) inverter / divider (polynomial basis).
//             Computes den^(2^M-2) with one multiply and one square per
//             cycle; an optional extra multiply by num yields num/den.
//  Revision : 1.0  initial release
//
//  Ports
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_valid   request valid
//    in_ready   block can accept a request (state-decoded, IDLE only)
//    in_div     0: den^-1, 1: num*den^-1
//    in_num     numerator (ignored when in_div=0)
//    in_den     denominator / operand to invert
//    out_valid  result valid (held until out_ready)
//    out_ready  consumer accepts result
//    out_data   result, polynomial basis (0 when den was 0)
//    out_zero   den was 0, inverse undefined
// ============================================================================
module gf_inv_div_seq #(
  parameter int             M    = 13,
  parameter logic [M-1:0]   POLY = M'(16'h001B)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_div,
  input  logic [M-1:0] in_num,
  input  logic [M-1:0] in_den,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_zero
);

  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [M-1:0]   sq_q, sq_d;
  logic [M-1:0]   num_q, num_d;
  logic           div_q, div_d;
  logic           zero_q, zero_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [M-1:0]   sq_in, sq_out;
  logic [M-1:0]   mul_b, prod;

  // Shift-and-add multiply, MSB of b first; each step doubles the partial
  // result (reducing x^M back through POLY) and then adds a if the bit is set.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                           input logic [M-1:0] b);
    logic [M-1:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY : '0);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // Squaring in GF(2^M) is linear: spread the bits to even positions,
  // then fold the upper M-1 terms down from the top.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i] = a[i];
    for (int k = 2*M - 2; k >= M; k--) begin
      if (s[k]) begin
        s[k] = 1'b0;
        s[k-M +: M] = s[k-M +: M] ^ POLY;
      end
    end
    return s[M-1:0];
  endfunction

  // One squarer and one multiplier are shared across states: the squarer
  // seeds den^2 on accept, and the multiplier takes num in the final step.
  assign sq_in  = (state_q == S_IDLE) ? in_den : sq_q;
  assign sq_out = gf_sq(sq_in);
  assign mul_b  = (state_q == S_MUL) ? num_q : sq_q;
  assign prod   = gf_mul(acc_q, mul_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      sq_q    <= '0;
      num_q   <= '0;
      div_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      num_q   <= num_d;
      div_q   <= div_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    num_d   = num_q;
    div_d   = div_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = M'(1);
          sq_d    = sq_out;
          num_d   = in_num;
          div_d   = in_div;
          zero_d  = (in_den == '0);
          cnt_d   = CW'(M - 2);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = prod;
        sq_d  = sq_out;
        if (cnt_q == '0) begin
          state_d = div_q ? S_MUL : S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_MUL: begin
        acc_d   = prod;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_zero  = (state_q == S_DONE) && zero_q;
  assign out_data  = ((state_q == S_DONE) && !zero_q) ? acc_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_gf_inv_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gf_inv_div_seq
//  Purpose  : Self-checking bench for gf_inv_div_seq. Two instances: M=13
//             (default polynomial) and M=4 (POLY=4'h3). A field model built
//             from carry-less multiply and square-and-multiply exponentiation
//             predicts every result, latency and handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gf_inv_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  in_valid, in_ready, in_div, out_valid, out_ready, out_zero;
  logic [15:0] in_num [2];
  logic [15:0] in_den [2];
  logic [15:0] out_data [2];
  logic [12:0] od_a;
  logic [3:0]  od_b;

  assign out_data[0] = {3'b0, od_a};
  assign out_data[1] = {12'b0, od_b};

  gf_inv_div_seq #(.M(13), .POLY(13'h001B)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_div(in_div[0]),
    .in_num(in_num[0][12:0]), .in_den(in_den[0][12:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(od_a), .out_zero(out_zero[0])
  );

  gf_inv_div_seq #(.M(4), .POLY(4'h3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_div(in_div[1]),
    .in_num(in_num[1][3:0]), .in_den(in_den[1][3:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(od_b), .out_zero(out_zero[1])
  );

  int          mm [2] = '{13, 4};
  int unsigned pl [2] = '{32'h1B, 32'h3};

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit bp     = 1'b0;

  // Per-instance scoreboard: at most one request is ever outstanding.
  bit [1:0]    busy = '0;
  bit [1:0]    seen = '0;
  int          acc_cyc [2];
  int          lat     [2];
  int unsigned exp_d   [2];
  bit          exp_z   [2];
  int unsigned last_d  [2];
  bit          last_z  [2];

  // ---------------- field model ----------------
  function automatic int unsigned fmul(input int unsigned a, input int unsigned b,
                                       input int m, input int unsigned poly);
    int unsigned p = 0;
    int unsigned full = (32'd1 << m) | poly;
    for (int i = 0; i < m; i++) if (b[i]) p ^= (a << i);
    for (int k = 2*m - 2; k >= m; k--) if (p[k]) p ^= (full << (k - m));
    return p;
  endfunction

  function automatic int unsigned finv(input int unsigned a, input int m,
                                       input int unsigned poly);
    int unsigned r = 1;
    int unsigned base = a;
    int unsigned e = (32'd1 << m) - 2;
    while (e != 0) begin
      if (e[0]) r = fmul(r, base, m, poly);
      base = fmul(base, base, m, poly);
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = '0;
      seen = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int unsigned msk, inv;
        chk("in_ready", in_ready[i], !busy[i]);
        if (out_valid[i]) begin
          if (!busy[i]) chk("out_valid idle", out_valid[i], 0);
          else begin
            if (!seen[i]) begin
              seen[i] = 1'b1;
              chk("latency", cyc - acc_cyc[i], lat[i]);
            end
            chk("out_data", out_data[i], exp_d[i]);
            chk("out_zero", out_zero[i], exp_z[i]);
            if (out_ready[i]) begin
              busy[i]   = 1'b0;
              last_d[i] = out_data[i];
              last_z[i] = out_zero[i];
            end
          end
        end else if (busy[i] && seen[i]) begin
          chk("out_valid held", out_valid[i], 1);
        end
        if (in_valid[i] && in_ready[i]) begin
          msk        = (32'd1 << mm[i]) - 1;
          busy[i]    = 1'b1;
          seen[i]    = 1'b0;
          acc_cyc[i] = cyc + 1;
          lat[i]     = mm[i] - 1 + int'(in_div[i]);
          exp_z[i]   = ((in_den[i] & msk) == 0);
          inv        = finv(in_den[i] & msk, mm[i], pl[i]);
          exp_d[i]   = exp_z[i] ? 0 :
                       (in_div[i] ? fmul(in_num[i] & msk, inv, mm[i], pl[i]) : inv);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int i, input bit dv, input int unsigned num,
                      input int unsigned den);
    int n = 0;
    @(posedge clk); #1;
    in_valid[i] = 1'b1;
    in_div[i]   = dv;
    in_num[i]   = num[15:0];
    in_den[i]   = den[15:0];
    forever begin
      @(negedge clk);
      if (in_ready[i]) break;
      n++;
      if (n > 2000) begin
        chk("accept timeout", in_ready[i], 1);
        break;
      end
    end
    @(posedge clk); #1;
    // Scramble inputs while busy; the result must not depend on them.
    in_valid[i] = 1'b0;
    in_div[i]   = 1'($urandom);
    in_num[i]   = 16'($urandom);
    in_den[i]   = 16'($urandom);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (busy[i]) chk("result timeout", busy[i], 0);
  endtask

  task automatic dir(input int i, input bit dv, input int unsigned num,
                     input int unsigned den, input int unsigned ed, input bit ez,
                     input string nm);
    send(i, dv, num, den);
    wait_idle(i);
    chk({nm, " data"}, last_d[i], ed);
    chk({nm, " zero"}, last_z[i], ez);
  endtask

  // Random backpressure on out_ready when bp is set.
  initial begin
    out_ready = '1;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++)
        out_ready[i] = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    in_valid = '0; in_div = '0;
    for (int i = 0; i < 2; i++) begin in_num[i] = '0; in_den[i] = '0; end

    chk("model mul 2*0x100D", fmul(2, 32'h100D, 13, 32'h1B), 1);
    chk("model inv13 2",      finv(2, 13, 32'h1B), 32'h100D);
    chk("model inv4 2",       finv(2, 4, 32'h3), 32'h9);

    #2 rst_n = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("reset out_valid", out_valid[i], 0);
      chk("reset in_ready",  in_ready[i], 1);
      chk("reset out_data",  out_data[i], 0);
      chk("reset out_zero",  out_zero[i], 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases
    dir(0, 1'b0, 0,       2, 32'h100D, 1'b0, "inv 2");
    dir(0, 1'b0, 0,       1, 32'h1,    1'b0, "inv 1");
    dir(0, 1'b1, 1,       2, 32'h100D, 1'b0, "div 1/2");
    dir(0, 1'b1, 2,       2, 32'h1,    1'b0, "div 2/2");
    dir(0, 1'b1, 0,       2, 32'h0,    1'b0, "div 0/2");
    dir(0, 1'b0, 0,       0, 32'h0,    1'b1, "inv 0");
    dir(0, 1'b1, 32'h1234, 0, 32'h0,   1'b1, "div 1234/0");
    dir(1, 1'b0, 0,       2, 32'h9,    1'b0, "m4 inv 2");

    // Reset in the middle of CALC: no result, idle immediately.
    send(0, 1'b0, 0, 2);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", out_valid[0], 0);
    chk("midreset in_ready",  in_ready[0], 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("post-reset no result", out_valid[0], 0);
    dir(0, 1'b0, 0, 2, 32'h100D, 1'b0, "after reset inv 2");

    bp = 1'b1;

    // M=4: every nonzero element, inverse and self-divide, plus zero.
    for (int d = 1; d < 16; d++) begin
      send(1, 1'b0, 0, d); wait_idle(1);
      chk("m4 inv*den", fmul(last_d[1], d, 4, 32'h3), 1);
      send(1, 1'b1, d, d); wait_idle(1);
      chk("m4 den/den", last_d[1], 1);
    end
    send(1, 1'b1, 5, 0); wait_idle(1);

    // M=13: random nonzero operands under backpressure.
    for (int k = 0; k < 800; k++) begin
      int unsigned d;
      d = $urandom_range(1, 8191);
      send(0, 1'b0, 0, d); wait_idle(0);
      chk("inv*den", fmul(last_d[0], d, 13, 32'h1B), 1);
      send(0, 1'b1, d, d); wait_idle(0);
      chk("den/den", last_d[0], 1);
    end
    for (int k = 0; k < 300; k++) begin
      int unsigned d, n;
      d = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 8191);
      n = $urandom_range(0, 8191);
      send(0, 1'($urandom), n, d); wait_idle(0);
    end

    bp = 1'b0;
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
